snake_plot_arbiter: RTL
=======================

SNAKE_PLOT_ARBITER -- requirements
Module: snake_plot_arbiter

Interface
REQ-001 Parameter X_W, default 8: width of pixel x coordinate.
REQ-002 Parameter Y_W, default 7: width of pixel y coordinate.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  per-requester block-draw request; 0 = screen clear, 1 = snake body, 2 = food.
REQ-006 req_x  input  3*X_W  per-requester block base x; requester i occupies bits [i*X_W +: X_W].
REQ-007 req_y  input  3*Y_W  per-requester block base y, packed as req_x.
REQ-008 req_colour  input  9  per-requester 3-bit colour, packed as req_x.
REQ-009 abort  input  1  synchronous burst kill, e.g. on death.
REQ-010 grant  output  3  one-hot owner of the plot port; 0 when idle.
REQ-011 done  output  3  one-cycle pulse on the owner bit when its block completes.
REQ-012 vga_x  output  X_W  pixel x to VGA adapter.
REQ-013 vga_y  output  Y_W  pixel y to VGA adapter.
REQ-014 vga_colour  output  3  pixel colour to VGA adapter.
REQ-015 vga_plot  output  1  pixel write enable.

Function
REQ-016 FSM states: IDLE, BURST, DONE; exactly one active at any time.
REQ-017 IDLE: if any req bit is high and abort is low, select one requester, latch its x, y and colour, clear the 4-bit pixel counter, and go to BURST; otherwise stay in IDLE.
REQ-018 Selection without PLOT_RR_EN: fixed priority 0 > 1 > 2.
REQ-019 BURST: vga_plot = 1; vga_x = latched x + cnt[1:0]; vga_y = latched y + cnt[3:2]; vga_colour = latched colour; cnt increments each cycle.
REQ-020 BURST lasts exactly 16 cycles (cnt 0..15, row-major 4x4 block); at cnt == 15 go to DONE.
REQ-021 Coordinate adds are truncated to X_W or Y_W bits; overflow wraps, with no clamping.
REQ-022 DONE: done[owner] = 1 for exactly one cycle, vga_plot = 0; next state IDLE.
REQ-023 grant is one-hot on the owner bit throughout BURST and DONE, and 0 in IDLE.
REQ-024 First plot occurs one cycle after req is sampled in IDLE; minimum request-to-request spacing is 18 cycles.
REQ-025 Changes to req, req_x, req_y or req_colour during BURST have no effect; a dropped req does not shorten the burst.
REQ-026 A requester that holds req high after its done pulse is re-arbitrated in the following IDLE cycle.
REQ-027 abort high in BURST or DONE forces IDLE at the next edge with no done pulse; abort takes precedence over cnt == 15.
REQ-028 abort high in IDLE blocks any new grant that cycle.
REQ-029 vga_x, vga_y and vga_colour are 0 whenever vga_plot is 0.

Reset
REQ-030 rst low asynchronously forces IDLE, cnt = 0, latched x/y/colour = 0, grant = 0, done = 0, vga_plot = 0, vga_x/vga_y/vga_colour = 0, and RR pointer = 2.
REQ-031 Reset mid-burst discards the burst; no done pulse is produced after reset release.

Configuration
REQ-032 Macro PLOT_RR_EN defined: round-robin selection; search starts at (last granted + 1) mod 3; pointer updates on the IDLE-to-BURST transition only.
REQ-033 PLOT_RR_EN undefined: fixed priority per REQ-018; the pointer register is not present.

Verification
REQ-034 Single req[1], x=10, y=20, colour=3'b111 -> 16 plots at (10..13, 20..23) row-major, then done[1] pulse at cycle 18.
REQ-035 req = 3'b111 held, fixed priority -> grants are 0, 0, 0...; with PLOT_RR_EN -> grant order 0, 1, 2, 0.
REQ-036 req[2] with x = 2^X_W - 2 -> vga_x sequence wraps to 254, 255, 0, 1 (for X_W = 8).
REQ-037 abort asserted at burst cycle 7 -> vga_plot low from cycle 8, no done pulse, grant = 0.
REQ-038 rst pulsed low at burst cycle 5 -> all outputs 0 immediately; after release with req low, outputs stay idle and no done pulse occurs.

Source files
------------

// File: rtl/snake_plot_arbiter.sv
// Three-way arbiter that hands the VGA plot port to one requester for a 4x4 pixel block burst.
// Define PLOT_RR_EN for round-robin selection; otherwise fixed priority 0 > 1 > 2.
module snake_plot_arbiter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         req,
  input  logic [3*X_W-1:0]   req_x,
  input  logic [3*Y_W-1:0]   req_y,
  input  logic [8:0]         req_colour,
  input  logic               abort,
  output logic [2:0]         grant,
  output logic [2:0]         done,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [3:0]     cnt_nxt;
  logic [X_W-1:0] lat_x;
  logic [Y_W-1:0] lat_y;
  logic [2:0]     lat_colour;
  logic [1:0]     sel;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [2:0]     sel_colour;

`ifdef PLOT_RR_EN
  logic [1:0] last;

  // Search begins one past the last owner and wraps modulo 3.
  always_comb begin
    sel = 2'd0;
    case (last)
      2'd0:    if (req[1]) sel = 2'd1; else if (req[2]) sel = 2'd2; else sel = 2'd0;
      2'd1:    if (req[2]) sel = 2'd2; else if (req[0]) sel = 2'd0; else sel = 2'd1;
      default: if (req[0]) sel = 2'd0; else if (req[1]) sel = 2'd1; else sel = 2'd2;
    endcase
  end
`else
  always_comb begin
    sel = 2'd0;
    if (req[0])      sel = 2'd0;
    else if (req[1]) sel = 2'd1;
    else             sel = 2'd2;
  end
`endif

  assign sel_x      = req_x[int'(sel)*X_W +: X_W];
  assign sel_y      = req_y[int'(sel)*Y_W +: Y_W];
  assign sel_colour = req_colour[int'(sel)*3 +: 3];
  assign cnt_nxt    = cnt + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_colour <= '0;
      grant      <= '0;
      done       <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
`ifdef PLOT_RR_EN
      last       <= 2'd2;
`endif
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req && !abort) begin
            state      <= BURST;
            cnt        <= '0;
            lat_x      <= sel_x;
            lat_y      <= sel_y;
            lat_colour <= sel_colour;
            grant      <= 3'b001 << sel;
            vga_plot   <= 1'b1;
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
`ifdef PLOT_RR_EN
            last       <= sel;
`endif
          end
        end
        BURST: begin
          if (abort) begin
            state      <= IDLE;
            grant      <= '0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
          end else if (cnt == 4'd15) begin
            state      <= DONE;
            done       <= grant;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
          end else begin
            // Pixel address is precomputed from the next count so outputs stay registered.
            cnt        <= cnt_nxt;
            vga_x      <= lat_x + X_W'(cnt_nxt[1:0]);
            vga_y      <= lat_y + Y_W'(cnt_nxt[3:2]);
            vga_colour <= lat_colour;
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          cnt   <= '0;
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          vga_plot <= 1'b0;
        end
      endcase
    end
  end

endmodule
